// File: rtl/or1k_pic_irq.sv
// OpenRISC PIC: synchronises external lines, holds PICMR/PICSR and arbitrates
// external vs tick-timer interrupts into one exception request.
module or1k_pic_irq #(
    parameter int unsigned NUM_IRQS    = 32,
    parameter logic [31:0] EDGE_MASK   = 32'h0,
    parameter logic [31:0] NMI_MASK    = 32'h3,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IRQS-1:0] irq_i,
    input  logic [31:0]         spr_ttmr_i,
    input  logic                spr_sr_iee_i,
    input  logic                spr_sr_tee_i,
    input  logic                spr_access_i,
    input  logic                spr_we_i,
    input  logic [15:0]         spr_addr_i,
    input  logic [31:0]         spr_dat_i,
    output logic                spr_bus_ack,
    output logic [31:0]         spr_dat_o,
    output logic [31:0]         spr_picmr_o,
    output logic [31:0]         spr_picsr_o,
    output logic                exc_req_o,
    output logic                exc_cause_o,
    input  logic                exc_ack_i
);

    localparam logic [15:0] OR1K_SPR_PICMR_ADDR = 16'h4800;
    localparam logic [15:0] OR1K_SPR_PICSR_ADDR = 16'h4802;

    localparam logic [31:0] VALID_MASK = (NUM_IRQS >= 32) ? 32'hffff_ffff
                                       : ((32'h1 << NUM_IRQS) - 32'h1);
    localparam logic [31:0] NMI_VALID  = NMI_MASK & VALID_MASK;

    function automatic logic [10:0] spr_offset(input logic [15:0] addr);
        return addr[10:0];
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_CLR
    } arb_state_e;

    logic [31:0] irq_w;
    logic [31:0] sync_d [SYNC_STAGES];
    logic [31:0] sync_q [SYNC_STAGES];
    logic [31:0] irq_s;
    logic [31:0] irq_d_d, irq_d_q;
    logic [31:0] picmr_d, picmr_q;
    logic [31:0] picsr_d, picsr_q;
    logic [31:0] edge_set, edge_clr, lvl_bits;
    logic        sel_picmr, sel_picsr;
    logic        wr_picmr, wr_picsr;
    logic        ext_pend, tick_pend, cur_pend;

    arb_state_e  state_q;
    logic        exc_req_q;
    logic        cause_q;

    logic        unused_bits;
    assign unused_bits = ^{spr_addr_i[15:11], spr_ttmr_i[31:30], spr_ttmr_i[27:0]};

    always_comb begin
        irq_w = '0;
        irq_w[NUM_IRQS-1:0] = irq_i;
    end

    always_comb begin
        sync_d[0] = irq_w & VALID_MASK;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign irq_s   = sync_q[SYNC_STAGES-1];
    assign irq_d_d = irq_s;

    assign sel_picmr = spr_offset(spr_addr_i) == spr_offset(OR1K_SPR_PICMR_ADDR);
    assign sel_picsr = spr_offset(spr_addr_i) == spr_offset(OR1K_SPR_PICSR_ADDR);
    assign wr_picmr  = spr_access_i & spr_we_i & sel_picmr;
    assign wr_picsr  = spr_access_i & spr_we_i & sel_picsr;

    always_comb begin
        picmr_d = picmr_q;
        if (wr_picmr) begin
            picmr_d = (spr_dat_i | NMI_MASK) & VALID_MASK;
        end
    end

    // Level bits follow the line; edge bits are sticky, a new edge beats a clear.
    always_comb begin
        lvl_bits = irq_s & picmr_q & ~EDGE_MASK;
        edge_set = irq_s & ~irq_d_q & picmr_q & EDGE_MASK;
        edge_clr = wr_picsr ? (spr_dat_i & EDGE_MASK) : 32'h0;
        picsr_d  = (lvl_bits | (picsr_q & EDGE_MASK & ~edge_clr) | edge_set)
                 & VALID_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            irq_d_q <= '0;
            picmr_q <= NMI_VALID;
            picsr_q <= '0;
        end else begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            irq_d_q <= irq_d_d;
            picmr_q <= picmr_d;
            picsr_q <= picsr_d;
        end
    end

    assign ext_pend  = (|picsr_q) & spr_sr_iee_i;
    assign tick_pend = spr_ttmr_i[29] & spr_ttmr_i[28] & spr_sr_tee_i;
    assign cur_pend  = cause_q ? tick_pend : ext_pend;

    // Cause is latched on entry to REQ and only re-arbitrated back in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            exc_req_q <= 1'b0;
            cause_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tick_pend) begin
                        state_q   <= REQ;
                        exc_req_q <= 1'b1;
                        cause_q   <= 1'b1;
                    end else if (ext_pend) begin
                        state_q   <= REQ;
                        exc_req_q <= 1'b1;
                        cause_q   <= 1'b0;
                    end
                end
                REQ: begin
                    if (exc_ack_i) begin
                        state_q   <= WAIT_CLR;
                        exc_req_q <= 1'b0;
                    end else if (!cur_pend) begin
                        state_q   <= IDLE;
                        exc_req_q <= 1'b0;
                    end
                end
                WAIT_CLR: begin
                    if (!cur_pend) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    exc_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        spr_dat_o = 32'h0;
        if (spr_access_i) begin
            if (sel_picmr) begin
                spr_dat_o = picmr_q;
            end else if (sel_picsr) begin
                spr_dat_o = picsr_q;
            end
        end
    end

    assign spr_bus_ack = spr_access_i;
    assign spr_picmr_o = picmr_q;
    assign spr_picsr_o = picsr_q;
    assign exc_req_o   = exc_req_q;
    assign exc_cause_o = cause_q;

endmodule

// File: tb/tb_or1k_pic_irq.sv
// Scoreboard bench for or1k_pic_irq: stimulus pushes expected SPR reads and
// exception request transitions; a negedge monitor pops and compares them.
module tb_or1k_pic_irq;

    localparam logic [15:0] PICMR = 16'h4800;
    localparam logic [15:0] PICSR = 16'h4802;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] irq;
    logic [31:0] ttmr;
    logic        iee, tee;
    logic        spr_access_i, spr_we_i;
    logic [15:0] spr_addr_i;
    logic [31:0] spr_dat_i;
    logic        spr_bus_ack;
    logic [31:0] spr_dat_o, spr_picmr_o, spr_picsr_o;
    logic        exc_req_o, exc_cause_o, exc_ack_i;

    or1k_pic_irq #(
        .NUM_IRQS   (32),
        .EDGE_MASK  (32'h10),
        .NMI_MASK   (32'h3),
        .SYNC_STAGES(2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .irq_i       (irq),
        .spr_ttmr_i  (ttmr),
        .spr_sr_iee_i(iee),
        .spr_sr_tee_i(tee),
        .spr_access_i(spr_access_i),
        .spr_we_i    (spr_we_i),
        .spr_addr_i  (spr_addr_i),
        .spr_dat_i   (spr_dat_i),
        .spr_bus_ack (spr_bus_ack),
        .spr_dat_o   (spr_dat_o),
        .spr_picmr_o (spr_picmr_o),
        .spr_picsr_o (spr_picsr_o),
        .exc_req_o   (exc_req_o),
        .exc_cause_o (exc_cause_o),
        .exc_ack_i   (exc_ack_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] val;
        string       name;
    } rd_t;

    typedef struct {
        bit    lvl;
        bit    cause;
        int    cyc;
        string name;
    } exc_t;

    rd_t  rd_q[$];
    exc_t exc_q[$];
    rd_t  re;
    exc_t ee;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic req_prev = 1'b0;
    bit   done = 1'b0;

    always @(negedge clk) begin
        if (spr_bus_ack && !spr_we_i) begin
            n_tests++;
            if (rd_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got %h, none expected", spr_dat_o);
            end else begin
                re = rd_q.pop_front();
                if (spr_dat_o !== re.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", re.name, spr_dat_o, re.val);
                end
            end
        end
        if (exc_req_o !== req_prev) begin
            n_tests++;
            if (exc_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_req: exc_req_o=%b at cycle %0d", exc_req_o, cyc);
            end else begin
                ee = exc_q.pop_front();
                if (exc_req_o !== ee.lvl || cyc != ee.cyc
                    || (ee.lvl && exc_cause_o !== ee.cause)) begin
                    n_fail++;
                    $display("FAIL %s: got req=%b cause=%b cycle=%0d expected req=%b cause=%b cycle=%0d",
                             ee.name, exc_req_o, exc_cause_o, cyc, ee.lvl, ee.cause, ee.cyc);
                end
            end
        end
        req_prev = exc_req_o;
        if (done) begin
            n_tests++;
            if (rd_q.size() != 0) begin
                n_fail++;
                $display("FAIL rd_leftover: got %0d pending reads expected 0", rd_q.size());
            end
            n_tests++;
            if (exc_q.size() != 0) begin
                n_fail++;
                $display("FAIL exc_leftover: got %0d unseen req events expected 0 (first %s)",
                         exc_q.size(), exc_q[0].name);
            end
            $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
            $finish;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [15:0] a, input logic [31:0] v, input string nm);
        rd_q.push_back('{v, nm});
        spr_access_i = 1'b1;
        spr_we_i     = 1'b0;
        spr_addr_i   = a;
        step();
        spr_access_i = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        spr_access_i = 1'b1;
        spr_we_i     = 1'b1;
        spr_addr_i   = a;
        spr_dat_i    = d;
        step();
        spr_access_i = 1'b0;
        spr_we_i     = 1'b0;
    endtask

    task automatic expx(input bit lvl, input bit cause, input int c, input string nm);
        exc_q.push_back('{lvl, cause, c, nm});
    endtask

    int k;

    initial begin
        rst = 1'b1;
        irq = '0;
        ttmr = '0;
        iee = 1'b0;
        tee = 1'b0;
        spr_access_i = 1'b0;
        spr_we_i = 1'b0;
        spr_addr_i = '0;
        spr_dat_i = '0;
        exc_ack_i = 1'b0;
        step(3);
        rst = 1'b0;

        rd(PICMR, 32'h3, "rst_picmr");
        rd(PICSR, 32'h0, "rst_picsr");

        // level line 2: PICSR at +3, request at +4
        wr(PICMR, 32'h4);
        rd(PICMR, 32'h7, "picmr_wr");
        iee = 1'b1;
        k = cyc;
        irq[2] = 1'b1;
        expx(1'b1, 1'b0, k + 4, "lvl_req_rise");
        step(2);
        rd(PICSR, 32'h0, "lvl_picsr_c2");
        rd(PICSR, 32'h4, "lvl_picsr_c3");
        step(2);
        k = cyc;
        exc_ack_i = 1'b1;
        expx(1'b0, 1'b0, k + 1, "lvl_ack_fall");
        step();
        exc_ack_i = 1'b0;
        step(3);
        irq[2] = 1'b0;
        step(8);
        rd(PICSR, 32'h0, "lvl_picsr_clr");

        // edge line 4
        iee = 1'b0;
        wr(PICMR, 32'h10);
        rd(PICMR, 32'h13, "picmr_edge");
        irq[4] = 1'b1;
        step();
        irq[4] = 1'b0;
        step(4);
        rd(PICSR, 32'h10, "edge_latched");
        wr(PICSR, 32'h0);
        rd(PICSR, 32'h10, "edge_wr0");
        wr(PICSR, 32'h10);
        rd(PICSR, 32'h0, "edge_clr");
        irq[4] = 1'b1;
        step();
        irq[4] = 1'b0;
        step();
        wr(PICSR, 32'h10);
        rd(PICSR, 32'h10, "edge_set_wins");

        // tick and external together: tick first
        k = cyc;
        iee = 1'b1;
        tee = 1'b1;
        ttmr = 32'h3000_0000;
        expx(1'b1, 1'b1, k + 1, "tick_first");
        step(3);
        k = cyc;
        exc_ack_i = 1'b1;
        expx(1'b0, 1'b1, k + 1, "tick_ack");
        step();
        exc_ack_i = 1'b0;
        step();
        k = cyc;
        ttmr = 32'h2000_0000;
        expx(1'b1, 1'b0, k + 2, "ext_after_tick");
        step(4);

        // retraction before ack
        k = cyc;
        iee = 1'b0;
        expx(1'b0, 1'b0, k + 1, "retract");
        step(3);

        // ack and retraction together: ack wins, stays in WAIT_CLR
        k = cyc;
        iee = 1'b1;
        expx(1'b1, 1'b0, k + 1, "rereq");
        step(3);
        k = cyc;
        exc_ack_i = 1'b1;
        iee = 1'b0;
        expx(1'b0, 1'b0, k + 1, "ack_vs_retract");
        step();
        exc_ack_i = 1'b0;
        iee = 1'b1;
        step(6);
        wr(PICSR, 32'h10);
        step(3);
        rd(PICSR, 32'h0, "wait_clr_done");
        iee = 1'b0;
        tee = 1'b0;
        ttmr = '0;

        // NMI line 0 cannot be masked
        wr(PICMR, 32'h0);
        rd(PICMR, 32'h3, "picmr_nmi");
        irq[0] = 1'b1;
        step(3);
        rd(PICSR, 32'h1, "nmi_lvl");

        // reset mid-request
        k = cyc;
        iee = 1'b1;
        expx(1'b1, 1'b0, k + 1, "pre_rst_req");
        step(3);
        k = cyc;
        rst = 1'b1;
        irq = '0;
        iee = 1'b0;
        expx(1'b0, 1'b0, k + 1, "rst_drop");
        step(2);
        rst = 1'b0;
        rd(PICMR, 32'h3, "post_rst_picmr");
        rd(PICSR, 32'h0, "post_rst_picsr");
        step(5);
        done = 1'b1;
    end

endmodule
